// File: rtl/en_strobe_gen.sv
// rtl/en_strobe_gen.sv - programmable single-cycle enable strobe with period, burst count and start/stop control
module en_strobe_gen #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               cfg_vld,
    output logic               cfg_rdy,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t             state, state_n;
    logic [CNT_W-1:0]   period_r, period_n;
    logic [BURST_W-1:0] burst_r, burst_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BURST_W-1:0] rem, rem_n;
    logic               en_n, done_n, err_n;

    assign cfg_rdy = (state == IDLE);
    assign busy_o  = (state == RUN);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            period_r <= CNT_ONE;
            burst_r  <= BURST_ONE;
            cnt      <= '0;
            rem      <= '0;
            en_o     <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_n;
            period_r <= period_n;
            burst_r  <= burst_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            en_o     <= en_n;
            done_o   <= done_n;
            err_o    <= err_n;
        end
    end

    // rem counts enables still owed after the one just issued; burst_r == 0 means run until stop
    always_comb begin
        state_n  = state;
        period_n = period_r;
        burst_n  = burst_r;
        cnt_n    = cnt;
        rem_n    = rem;
        en_n     = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_vld) begin
                    if (cfg_period == '0) begin
                        err_n = 1'b1;
                    end else begin
                        period_n = cfg_period;
                        burst_n  = cfg_burst;
                    end
                end
                // start always uses the registers as they stood before any same-cycle config load
                if (start && !stop) begin
                    en_n  = 1'b1;
                    cnt_n = period_r - CNT_ONE;
                    rem_n = burst_r - BURST_ONE;
                    if (burst_r == BURST_ONE) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    en_n  = 1'b1;
                    cnt_n = period_r - CNT_ONE;
                    if (burst_r != '0) begin
                        rem_n = rem - BURST_ONE;
                        if (rem == BURST_ONE) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
